hex_word_printer: RTL and testbench

Converts a binary word into its ASCII hexadecimal representation and streams the characters, MSB nibble first, optionally prefixed with "0x" and terminated with CR LF. It sits directly upstream of `uart_tx`. Its byte output drives `uart_tx` `data`/`valid` and takes `uart_tx` `ready` as backpressure, so that status and debug words can be printed on the serial console. One word is accepted at a time; a new word is not accepted until the last character of the previous one has been handed off.

---
 rtl/hex_word_printer.sv | 100 ++++++++++
 tb/tb_hex_word_printer.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/hex_word_printer.sv
// Prints one binary word as ASCII hex (MSB nibble first) on a valid/ready byte
// stream, with an optional "0x" prefix and CR LF suffix.
module hex_word_printer #(
  parameter int DIGITS    = 8,
  parameter int PREFIX    = 1,
  parameter int NEWLINE   = 1,
  parameter int UPPERCASE = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [4*DIGITS-1:0]   in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [7:0]            out_data,
  output logic                  busy
);

  localparam int DATA_W = 4 * DIGITS;

  typedef enum logic [2:0] {IDLE, PFX0, PFX1, DIGIT, CR, LF} state_t;

  state_t              state, state_n;
  logic [DATA_W-1:0]   sreg, sreg_n;
  logic [3:0]          cnt, cnt_n;
  logic                armed;
  logic                out_fire;
  logic [7:0]          char_n;

  function automatic logic [7:0] hex_char(input logic [3:0] nib);
    if (nib < 4'd10)         return 8'h30 + {4'h0, nib};
    else if (UPPERCASE != 0) return 8'h37 + {4'h0, nib};
    else                     return 8'h57 + {4'h0, nib};
  endfunction

  function automatic logic [7:0] state_char(input state_t s, input logic [3:0] nib);
    case (s)
      PFX0:    return 8'h30;
      PFX1:    return 8'h78;
      DIGIT:   return hex_char(nib);
      CR:      return 8'h0D;
      LF:      return 8'h0A;
      default: return 8'h00;
    endcase
  endfunction

  // armed stays low for the first cycle after reset so in_ready rises one edge later
  assign in_ready = armed && (state == IDLE);
  assign busy     = (state != IDLE);
  assign out_fire = out_valid && out_ready;

  always_comb begin
    state_n = state;
    sreg_n  = sreg;
    cnt_n   = cnt;
    case (state)
      IDLE: begin
        if (in_valid && in_ready) begin
          sreg_n  = in_data;
          cnt_n   = 4'(DIGITS - 1);
          state_n = (PREFIX != 0) ? PFX0 : DIGIT;
        end
      end
      PFX0: if (out_fire) state_n = PFX1;
      PFX1: if (out_fire) state_n = DIGIT;
      DIGIT: begin
        if (out_fire) begin
          sreg_n = sreg << 4;
          cnt_n  = cnt - 4'd1;
          if (cnt == 4'd0) state_n = (NEWLINE != 0) ? CR : IDLE;
        end
      end
      CR: if (out_fire) state_n = LF;
      LF: if (out_fire) state_n = IDLE;
      default: state_n = IDLE;
    endcase
    // The character register follows the next state, so a stall leaves it untouched
    char_n = state_char(state_n, sreg_n[DATA_W-1 -: 4]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      sreg      <= '0;
      cnt       <= '0;
      out_valid <= 1'b0;
      out_data  <= 8'h00;
      armed     <= 1'b0;
    end else begin
      state     <= state_n;
      sreg      <= sreg_n;
      cnt       <= cnt_n;
      out_valid <= (state_n != IDLE);
      out_data  <= char_n;
      armed     <= 1'b1;
    end
  end

endmodule

// File: tb/tb_hex_word_printer.sv
// Bench for hex_word_printer: default instance plus a 2-digit lowercase, no-frame instance.
module tb_hex_word_printer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [7:0]  out_data;
  logic        busy;

  logic        in_valid2 = 1'b0;
  logic        in_ready2;
  logic [7:0]  in_data2 = '0;
  logic        out_valid2;
  logic        out_ready2 = 1'b1;
  logic [7:0]  out_data2;
  logic        busy2;

  int checks   = 0;
  int failures = 0;
  int tx_count = 0;
  logic [7:0] q[$];
  logic [7:0] q2[$];

  logic bp_mode = 1'b0;
  logic stalled_once = 1'b0;
  int   hold_cnt = 0;

  always #5 clk = ~clk;

  hex_word_printer dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy)
  );

  hex_word_printer #(.DIGITS(2), .PREFIX(0), .NEWLINE(0), .UPPERCASE(0)) dut2 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid2), .in_ready(in_ready2), .in_data(in_data2),
    .out_valid(out_valid2), .out_ready(out_ready2), .out_data(out_data2),
    .busy(busy2)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] model_char(input logic [3:0] nib, input bit upper);
    if (nib < 10) return 8'h30 + 8'(nib);
    return (upper ? 8'h41 : 8'h61) + 8'(nib) - 8'd10;
  endfunction

  task automatic push_word(input logic [31:0] w);
    q.push_back(8'h30);
    q.push_back(8'h78);
    for (int i = 7; i >= 0; i--) q.push_back(model_char(w[4*i +: 4], 1'b1));
    q.push_back(8'h0D);
    q.push_back(8'h0A);
  endtask

  // Transfers are predicted on the falling edge, where handshake signals are stable
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      checks++;
      assert (q.size() != 0) else begin
        failures++;
        $error("FAIL spurious_byte observed=%0h expected=none", out_data);
      end
      if (q.size() != 0) check("byte", out_data, q.pop_front());
      tx_count++;
    end
    if (!rst && out_valid2 && out_ready2) begin
      checks++;
      assert (q2.size() != 0) else begin
        failures++;
        $error("FAIL spurious_byte2 observed=%0h expected=none", out_data2);
      end
      if (q2.size() != 0) check("byte2", out_data2, q2.pop_front());
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (bp_mode) begin
      if (!stalled_once && out_valid && out_data == 8'h41) begin
        stalled_once = 1'b1;
        hold_cnt = 5;
      end
      if (hold_cnt > 0) begin
        check("stall_valid", out_valid, 1);
        check("stall_data", out_data, 8'h41);
        out_ready = 1'b0;
        hold_cnt--;
      end else begin
        out_ready = 1'($urandom_range(0, 1));
      end
    end
  endtask

  task automatic send(input logic [31:0] w);
    int n = 0;
    in_valid = 1'b1;
    in_data  = w;
    while (!in_ready && n < 200) begin tick(); n++; end
    check("accept_ready", in_ready, 1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((q.size() != 0 || !in_ready) && n < 400) begin tick(); n++; end
    check("drain_queue", q.size(), 0);
    check("drain_ready", in_ready, 1);
  endtask

  task automatic send2(input logic [7:0] w);
    in_valid2 = 1'b1;
    in_data2  = w;
    check("accept_ready2", in_ready2, 1);
    tick();
    in_valid2 = 1'b0;
  endtask

  initial begin
    int n;
    int base;

    // Reset state
    tick(); tick();
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 8'h00);
    check("rst_in_ready", in_ready, 0);
    check("rst_busy", busy, 0);
    rst = 1'b0;
    check("post_rst_in_ready_low", in_ready, 0);
    tick();
    check("post_rst_in_ready", in_ready, 1);
    check("post_rst_busy", busy, 0);
    check("post_rst_in_ready2", in_ready2, 1);

    // Back-to-back 12 bytes then in_ready on the 13th cycle
    push_word(32'hDEADBEEF);
    send(32'hDEADBEEF);
    for (int i = 0; i < 12; i++) begin
      check("stream_valid", out_valid, 1);
      check("stream_busy", busy, 1);
      tick();
    end
    check("ready_after_word", in_ready, 1);
    check("idle_out_valid", out_valid, 0);

    // Random backpressure with a 5-cycle stall on 'A'
    bp_mode = 1'b1;
    push_word(32'hDEADBEEF);
    send(32'hDEADBEEF);
    drain();
    bp_mode = 1'b0;
    out_ready = 1'b1;
    check("stall_happened", stalled_once, 1);

    // in_valid held while a word is printing: second word waits its turn
    in_valid = 1'b1;
    in_data  = 32'h0000000F;
    push_word(32'h0000000F);
    tick();
    in_data = 32'h12345678;
    push_word(32'h12345678);
    n = 0;
    while (!in_ready && n < 100) begin tick(); n++; end
    check("held_accept", in_ready, 1);
    tick();
    in_valid = 1'b0;
    drain();

    // Two-digit lowercase, no prefix, no newline
    q2.push_back(8'h61); q2.push_back(8'h62);
    send2(8'hAB);
    check("d2_valid0", out_valid2, 1);
    tick();
    check("d2_valid1", out_valid2, 1);
    tick();
    check("d2_idle_valid", out_valid2, 0);
    check("d2_idle_ready", in_ready2, 1);
    q2.push_back(8'h30); q2.push_back(8'h39);
    send2(8'h09);
    tick(); tick();
    check("d2_idle_ready_b", in_ready2, 1);
    check("d2_queue", q2.size(), 0);

    // Reset after the 4th character of 0xCAFEF00D
    base = tx_count;
    push_word(32'hCAFEF00D);
    send(32'hCAFEF00D);
    n = 0;
    while (tx_count < base + 4 && n < 100) begin tick(); n++; end
    check("abort_point", tx_count, base + 4);
    rst = 1'b1;
    q.delete();
    tick();
    check("abort_out_valid", out_valid, 0);
    check("abort_out_data", out_data, 8'h00);
    check("abort_in_ready", in_ready, 0);
    check("abort_busy", busy, 0);
    rst = 1'b0;
    tick();
    check("abort_ready_back", in_ready, 1);
    check("abort_quiet", out_valid, 0);
    tick(); tick();
    check("abort_no_bytes", tx_count, base + 4);
    push_word(32'hCAFEF00D);
    send(32'hCAFEF00D);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
